// File: rtl/div_pkg.sv
// Shared types for the round-robin divider scheduler.
// FSM state, default widths and the response record.
package div_pkg;

  localparam int DIV_WIDTH   = 16;
  localparam int DIV_NUM_REQ = 4;
  localparam int DIV_ID_W    = $clog2(DIV_NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic [DIV_ID_W-1:0]  id;
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 dbz;
  } rsp_t;

endpackage

// File: rtl/div_arbiter_if.sv
// Request/response bundle between requesters, consumer and div_arbiter.
// master: requesters + consumer side; slave: the arbiter.
interface div_arbiter_if
  import div_pkg::*;
#(
  parameter int NUM_REQ = DIV_NUM_REQ,
  parameter int WIDTH   = DIV_WIDTH
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_dividend;
  logic [NUM_REQ*WIDTH-1:0] req_divisor;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_quotient;
  logic [WIDTH-1:0]         rsp_remainder;
  logic                     rsp_dbz;
  logic                     busy;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id,
    input  rsp_quotient, rsp_remainder, rsp_dbz, busy
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id,
    output rsp_quotient, rsp_remainder, rsp_dbz, busy
  );

endinterface

// File: rtl/div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Ports: clk, rst_n, start, dividend, divisor -> done, quotient, remainder.
module div_core
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_run;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_trial;

  // Shifted acc keeps its carry-out bit so a divisor above
  // 2^(WIDTH-1) still compares correctly.
  assign w_sh    = {r_acc, r_q[WIDTH-1]};
  assign w_trial = w_sh - {1'b0, r_dvs};

  assign done      = r_run && (r_cnt == CW'(WIDTH - 1));
  assign quotient  = r_q;
  assign remainder = r_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_q   <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_acc <= '0;
      r_q   <= dividend;
      r_dvs <= divisor;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (w_trial[WIDTH]) begin
        r_acc <= w_sh[WIDTH-1:0];
        r_q   <= {r_q[WIDTH-2:0], 1'b0};
      end else begin
        r_acc <= w_trial[WIDTH-1:0];
        r_q   <= {r_q[WIDTH-2:0], 1'b1};
      end
      r_cnt <= r_cnt + 1'b1;
      if (done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one div_core among NUM_REQ requesters.
// Ports: clk, rst_n, bus (div_arbiter_if.slave: requests, response, busy).
module div_arbiter
  import div_pkg::*;
#(
  parameter int NUM_REQ = DIV_NUM_REQ,
  parameter int WIDTH   = DIV_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  div_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int SW  = IDW + 1;

  arb_state_t     r_state;
  arb_state_t     w_next;
  logic [IDW-1:0] r_last;
  logic [IDW-1:0] w_win;
  logic [SW-1:0]  w_sum;
  logic           w_found;
  logic           w_acc;
  logic           w_zero;
  logic           w_start;
  logic           w_done;
  logic           w_rv;
  logic [WIDTH-1:0] w_dvd;
  logic [WIDTH-1:0] w_dvs;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  rsp_t           r_rsp;
  rsp_t           w_rsp;

  // First valid requester searching upward from r_last+1.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, r_last} + SW'(k);
      if (w_sum >= SW'(NUM_REQ)) w_sum = w_sum - SW'(NUM_REQ);
      if (!w_found && bus.req_valid[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[IDW-1:0];
      end
    end
  end

  assign w_acc   = (r_state == IDLE) && rst_n && w_found;
  assign w_dvd   = bus.req_dividend[w_win*WIDTH +: WIDTH];
  assign w_dvs   = bus.req_divisor[w_win*WIDTH +: WIDTH];
  assign w_zero  = (w_dvs == '0);
  assign w_start = w_acc && !w_zero;

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      bus.req_ready[i] = w_acc && (w_win == IDW'(i));
  end

  div_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_start),
    .dividend  (w_dvd),
    .divisor   (w_dvs),
    .done      (w_done),
    .quotient  (w_q),
    .remainder (w_r)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_acc) w_next = w_zero ? RESP : CALC;
      CALC: if (w_done) w_next = RESP;
      RESP: if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Divide-by-zero result is built here; a normal result stays
  // in the idle core registers for the whole RESP phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= IDW'(NUM_REQ - 1);
      r_rsp  <= '0;
    end else if (w_acc) begin
      r_last          <= w_win;
      r_rsp.id        <= DIV_ID_W'(w_win);
      r_rsp.dbz       <= w_zero;
      r_rsp.quotient  <= '0;
      r_rsp.remainder <= w_zero ? DIV_WIDTH'(w_dvd) : '0;
    end
  end

  always_comb begin
    w_rsp = r_rsp;
    if (!r_rsp.dbz) begin
      w_rsp.quotient  = DIV_WIDTH'(w_q);
      w_rsp.remainder = DIV_WIDTH'(w_r);
    end
  end

  assign w_rv              = (r_state == RESP);
  assign bus.rsp_valid     = w_rv;
  assign bus.rsp_id        = w_rv ? IDW'(w_rsp.id) : '0;
  assign bus.rsp_quotient  = w_rv ? WIDTH'(w_rsp.quotient) : '0;
  assign bus.rsp_remainder = w_rv ? WIDTH'(w_rsp.remainder) : '0;
  assign bus.rsp_dbz       = w_rv && w_rsp.dbz;
  assign bus.busy          = (r_state != IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: vector table, scoreboard,
// round-robin order, backpressure and mid-divide reset sequences.
module tb_div_arbiter;
  import div_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

  typedef struct {
    int          id;
    logic [15:0] dvd;
    logic [15:0] dvs;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  div_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sb[$];
  int          grants[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] op_dvd[N];
  logic [15:0] op_dvs[N];
  vec_t        vt[9];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input int id, input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t e;
    e.id = 2'(id);
    if (b == 16'd0) begin
      e.q = 16'd0; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic set_op(input int id, input logic [15:0] a,
                        input logic [15:0] b);
    op_dvd[id] = a;
    op_dvs[id] = b;
    bus.req_dividend[id*W +: W] = a;
    bus.req_divisor[id*W +: W]  = b;
  endtask

  task automatic check_rsp();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_unexpected: got response id %0d, expected none",
               bus.rsp_id);
    end else begin
      e = sb.pop_front();
      chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
      chk("rsp_quotient", 32'(bus.rsp_quotient), 32'(e.q));
      chk("rsp_remainder", 32'(bus.rsp_remainder), 32'(e.r));
      chk("rsp_dbz", 32'(bus.rsp_dbz), 32'(e.dbz));
    end
  endtask

  // Serves all pending requests: records grants, drops a requester's
  // valid after its handshake, checks every response against the queue.
  task automatic run_until_idle(input int max);
    int g;
    bit fin;
    fin = 1'b0;
    for (int c = 0; c < max && !fin; c++) begin
      @(negedge clk);
      g = -1;
      if (bus.req_ready != '0) begin
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) g = i;
        chk("grant_onehot", $countones(bus.req_ready), 1);
        grants.push_back(g);
        sb.push_back(model(g, op_dvd[g], op_dvs[g]));
      end
      if (bus.rsp_valid && bus.rsp_ready) check_rsp();
      if (bus.req_valid == '0 && !bus.busy && sb.size() == 0) fin = 1'b1;
      @(posedge clk);
      #1;
      if (g >= 0) bus.req_valid[g] = 1'b0;
    end
    if (!fin) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: got busy after %0d cycles, expected idle",
               max);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    bit got;
    set_op(v.id, v.dvd, v.dvs);
    bus.req_valid = '0;
    bus.req_valid[v.id] = 1'b1;
    @(negedge clk);
    chk("vec_grant", 32'(bus.req_ready), 32'(1) << v.id);
    sb.push_back('{2'(v.id), v.q, v.r, v.dbz});
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    lat = 0;
    got = 1'b0;
    while (lat < 40 && !got) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) got = 1'b1;
    end
    chk("vec_latency", lat, v.lat);
    if (got) check_rsp();
    else sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vt[0] = '{0, 16'd100,    16'd7,      16'd14,     16'd2,      1'b0, 17};
    vt[1] = '{1, 16'h1234,   16'd0,      16'd0,      16'h1234,   1'b1, 1};
    vt[2] = '{2, 16'hFFFF,   16'd1,      16'hFFFF,   16'd0,      1'b0, 17};
    vt[3] = '{3, 16'd5,      16'd9,      16'd0,      16'd5,      1'b0, 17};
    vt[4] = '{0, 16'hFFFF,   16'hFFFF,   16'd1,      16'd0,      1'b0, 17};
    vt[5] = '{1, 16'd1000,   16'd10,     16'd100,    16'd0,      1'b0, 17};
    vt[6] = '{2, 16'h8000,   16'd3,      16'h2AAA,   16'd2,      1'b0, 17};
    vt[7] = '{3, 16'd0,      16'd0,      16'd0,      16'd0,      1'b1, 1};
    vt[8] = '{0, 16'hFFFE,   16'hFFFF,   16'd0,      16'hFFFE,   1'b0, 17};

    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.rsp_ready    = 1'b1;

    // Reset with every requester already valid.
    for (int i = 0; i < N; i++) set_op(i, 16'(16'h100 * (i + 1) + i), 16'd0);
    bus.req_valid = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_quotient", 32'(bus.rsp_quotient), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin from reset, then wrap from 3 to 0.
    run_until_idle(200);
    chk("rr_count", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grants.size())
        chk($sformatf("rr_order%0d", i), grants[i], i);
    grants.delete();
    set_op(0, 16'd77, 16'd3);
    set_op(2, 16'd91, 16'd5);
    bus.req_valid = 4'b0101;
    run_until_idle(200);
    chk("wrap_count", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("wrap_first", grants[0], 0);
      chk("wrap_second", grants[1], 2);
    end
    grants.delete();

    for (int i = 0; i < 9; i++) run_vec(vt[i]);

    // Backpressure: five stalled RESP cycles, accept on the sixth.
    set_op(2, 16'd100, 16'd7);
    set_op(0, 16'd50, 16'd6);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("bp_grant", 32'(bus.req_ready), 32'h4);
    sb.push_back(model(2, 16'd100, 16'd7));
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0001;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 40);
    chk("bp_latency", lat, 17);
    for (int s = 0; s < 5; s++) begin
      if (s > 0) @(negedge clk);
      chk("bp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_busy", 32'(bus.busy), 1);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
      chk("bp_quotient", 32'(bus.rsp_quotient), 14);
      chk("bp_remainder", 32'(bus.rsp_remainder), 2);
      chk("bp_id", 32'(bus.rsp_id), 2);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_accept", 32'(bus.rsp_valid), 1);
    check_rsp();
    @(negedge clk);
    chk("bp_next_grant", 32'(bus.req_ready), 32'h1);
    sb.push_back(model(0, 16'd50, 16'd6));
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    run_until_idle(60);

    // Reset during CALC iteration 8 discards the divide in flight.
    set_op(1, 16'd1000, 16'd7);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    chk("mr_grant", 32'(bus.req_ready), 32'h2);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_op(3, 16'd4321, 16'd17);
    bus.req_valid = 4'b1000;
    @(negedge clk);
    chk("mr_busy_pre", 32'(bus.busy), 1);
    chk("mr_ready_in_rst", 32'(bus.req_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_busy", 32'(bus.busy), 0);
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mr_quotient", 32'(bus.rsp_quotient), 0);
    chk("mr_remainder", 32'(bus.rsp_remainder), 0);
    chk("mr_id", 32'(bus.rsp_id), 0);
    chk("mr_dbz", 32'(bus.rsp_dbz), 0);
    chk("mr_grant3", 32'(bus.req_ready), 32'h8);
    sb.push_back(model(3, 16'd4321, 16'd17));
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    run_until_idle(60);

    // Random operands through the scoreboard.
    for (int i = 0; i < 8; i++) begin
      int id;
      logic [15:0] a;
      logic [15:0] b;
      id = $urandom_range(0, N - 1);
      a  = 16'($urandom);
      b  = (i == 3) ? 16'd0 : 16'($urandom_range(1, 65535) >> (i * 2));
      set_op(id, a, b);
      bus.req_valid = '0;
      bus.req_valid[id] = 1'b1;
      run_until_idle(60);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin scheduler that shares one 16-bit iterative restoring divider among NUM_REQ requesters. It accepts one operand pair at a time through a valid/ready handshake, sequences the divider core for 16 iterations, and returns quotient, remainder, divide-by-zero flag and requester ID on a single response port with backpressure. It sits between the operand-capture logic and display/consumer logic, so that several sources no longer need their own divider.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- WIDTH, 16, operand/result width; the core iterates exactly WIDTH times

Ports:
- clk  input  1  system clock; all logic is on the rising edge
- rst_n  input  1  synchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester operand valid
- req_dividend  input  NUM_REQ*WIDTH  packed dividends; requester i is at [i*WIDTH +: WIDTH]
- req_divisor  input  NUM_REQ*WIDTH  packed divisors, same packing as req_dividend
- req_ready  output  NUM_REQ  one-hot grant; handshake when req_valid[i] && req_ready[i]
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts the response
- rsp_id  output  $clog2(NUM_REQ)  index of the requester that owns the response
- rsp_quotient  output  WIDTH  quotient
- rsp_remainder  output  WIDTH  remainder
- rsp_dbz  output  1  divisor was zero
- busy  output  1  high whenever the state is not IDLE

## Operation
- States are IDLE, CALC and RESP.
- **IDLE**
  - Winner is the first asserted req_valid searching upward (with wrap) from last_grant+1.
  - req_ready[winner] is driven combinationally high in the same cycle; all other req_ready bits are 0. req_ready is 0 in every other state.
  - On handshake, dividend, divisor and ID are latched, and last_grant is set to the winner.
  - If divisor ≠ 0: load accumulator = 0, quotient register = dividend, iteration counter = 0, go to CALC.
  - If divisor = 0: result is q = 0, r = dividend, dbz = 1; go directly to RESP.
- **CALC** (one iteration per cycle, unsigned)
  - Shift {acc, q} left by 1.
  - trial = acc_shifted − divisor, computed at WIDTH+1 bits.
  - If trial is negative: keep acc_shifted and set the quotient LSB to 0. Otherwise: acc = trial and set the LSB to 1.
  - The counter increments each cycle; the iteration with counter = WIDTH−1 is the last, and the state moves to RESP.
- **RESP**
  - rsp_valid = 1. rsp_id, rsp_quotient, rsp_remainder and rsp_dbz are held stable until the handshake cycle (rsp_valid && rsp_ready), then the state returns to IDLE.
  - No new grant is issued while in RESP.
- Requesters must hold req_valid and operands stable until granted. A req_valid that drops before grant is simply not considered.
- Response outputs are 0 whenever rsp_valid = 0.

## Timing
- **Reset:** applies on any clock edge where rst_n = 0, including mid-CALC or mid-RESP.
  - Next state IDLE; the in-flight result is discarded.
  - All outputs 0 (req_ready is 0 while rst_n is low).
  - last_grant = NUM_REQ−1, so requester 0 has highest priority after reset.
- **Latency**, taking the accept cycle as T:
  - Normal divide: CALC occupies T+1..T+WIDTH (16 cycles); rsp_valid is first high at T+17.
  - Divisor of zero: rsp_valid is first high at T+1.
- **Back-to-back:** if rsp_ready is high in the first RESP cycle R, the next grant can occur at R+1. Minimum period is 18 cycles (normal) or 2 cycles (divide-by-zero).
- **Simultaneous events:** requests arriving during CALC/RESP wait for IDLE. A handshake in RESP and a new req_valid in the same cycle are fine: arbitration happens the following (IDLE) cycle.
- **Wrap-around:** the priority pointer wraps from NUM_REQ−1 to 0.
- **Edge values:** a dividend smaller than the divisor gives q = 0, r = dividend; divisor = 1 gives q = dividend, r = 0.

## Structure
- Package div_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, CALC, RESP}
  - localparam DIV_WIDTH = 16
  - a response struct typedef (id, quotient, remainder, dbz)
- Sub-module div_core contains the iterative datapath and counter.
  - Inputs: start, dividend, divisor.
  - Outputs: done (1-cycle pulse on the last iteration), quotient, remainder.
  - Receives the same synchronous rst_n.
- div_arbiter owns the round-robin pointer, the handshakes, the divide-by-zero bypass and the response holding register.

## Test plan
- Only req0 asserted with 100/7 → req_ready[0] high at T; rsp_valid at T+17 with q = 14, r = 2, dbz = 0, id = 0.
- req1 asserted with 0x1234/0 → rsp_valid at T+1 with q = 0, r = 0x1234, dbz = 1, id = 1.
- After reset, all four requesters held valid → grant order 0, 1, 2, 3. Next, req0 and req2 are asserted after the grant to req3 → order 0, then 2.
- rsp_ready held low for 5 cycles → outputs stable, busy = 1, no req_ready asserted; handshake on the 6th cycle, and the next grant comes the cycle after.
- rst_n pulled low during CALC iteration 8 → next cycle all outputs 0 and IDLE; a subsequent req3 gets a normal result.
- Corner operands: 0xFFFF/1 → q = 0xFFFF, r = 0; 5/9 → q = 0, r = 5; 0xFFFF/0xFFFF → q = 1, r = 0.
